// File: rtl/fetch.sv
// Instruction fetch stage. It keeps one request to instruction memory
// outstanding at most, holds a one-entry output register for decode, and
// handles branch redirects, misaligned PCs and access faults.
module fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic        valid_out,
    output logic        exception,
    output logic [3:0]  ecause
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ACCESS     = 4'd1;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        exc_q, exc_d;
    logic [3:0]  ecause_q, ecause_d;

    logic        buf_free;
    logic        accept;
    logic [31:0] pc_plus4;

    // The output slot can take a new entry if empty or being consumed now;
    // the request is therefore combinational on stall.
    assign buf_free = !valid_q || !stall;
    assign mem_req  = (state_q == S_REQ) && buf_free && (pc_q[1:0] == 2'b00);
    assign accept   = mem_req && mem_ready;
    assign pc_plus4 = pc_q + 32'd4;
    assign mem_addr = pc_q;

    // Next-state, PC and output-register update; a redirect overrides everything.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        next_pc_d = next_pc_q;
        exc_d     = exc_q;
        ecause_d  = ecause_q;

        if (valid_q && !stall) begin
            valid_d = 1'b0;
        end

        if (branch_taken) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = accept ? S_FLUSH : S_REQ;
                S_WAIT:  state_d = mem_rvalid ? S_REQ : S_FLUSH;
                S_FLUSH: state_d = mem_rvalid ? S_REQ : S_FLUSH;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (accept) begin
                        state_d = S_WAIT;
                    end else if ((pc_q[1:0] != 2'b00) && buf_free) begin
                        valid_d   = 1'b1;
                        instr_d   = 32'd0;
                        pc_out_d  = pc_q;
                        next_pc_d = pc_plus4;
                        exc_d     = 1'b1;
                        ecause_d  = CAUSE_MISALIGNED;
                        state_d   = S_HALT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        valid_d   = 1'b1;
                        pc_out_d  = pc_q;
                        next_pc_d = pc_plus4;
                        if (mem_error) begin
                            instr_d  = 32'd0;
                            exc_d    = 1'b1;
                            ecause_d = CAUSE_ACCESS;
                            state_d  = S_HALT;
                        end else begin
                            instr_d  = mem_rdata;
                            exc_d    = 1'b0;
                            ecause_d = 4'd0;
                            pc_d     = pc_plus4;
                            state_d  = S_REQ;
                        end
                    end
                end
                S_FLUSH: begin
                    // Response belongs to a redirected-away fetch: drop it.
                    if (mem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    // State and output register, cleared asynchronously by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_VECTOR;
            valid_q   <= 1'b0;
            instr_q   <= 32'd0;
            pc_out_q  <= 32'd0;
            next_pc_q <= 32'd0;
            exc_q     <= 1'b0;
            ecause_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            next_pc_q <= next_pc_d;
            exc_q     <= exc_d;
            ecause_q  <= ecause_d;
        end
    end

    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign next_pc_out = next_pc_q;
    assign valid_out   = valid_q;
    assign exception   = exc_q;
    assign ecause      = ecause_q;

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch: a table of per-cycle vectors for streaming and stall,
// then hand-written sequences for redirect, misalignment, faults, reset, wrap.
module tb_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] next_pc_out;
    logic        valid_out;
    logic        exception;
    logic [3:0]  ecause;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    logic [31:0] err_addr;

    fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_error     (mem_error),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .pc_out        (pc_out),
        .next_pc_out   (next_pc_out),
        .valid_out     (valid_out),
        .exception     (exception),
        .ecause        (ecause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at a cycle start; returns at the falling edge of the first valid cycle.
    task automatic wait_valid(input string name, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (valid_out) found = 1'b1;
            else step();
        end
        check({name, " valid within budget"}, {31'd0, found}, 32'd1);
    endtask

    // Memory model: one response per accepted request after 'lat' cycles.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend       = 1'b0;
        paddr      = 32'd0;
        cnt        = 0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        mem_error  = 1'b0;
        forever begin
            @(negedge clk);
            acc      = mem_req && mem_ready && resetn;
            acc_addr = mem_addr;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_error  = 1'b0;
            mem_rdata  = 32'd0;
            if (!resetn) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = acc_addr;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        mem_rvalid = 1'b1;
                        mem_error  = (paddr == err_addr);
                        mem_rdata  = (paddr == err_addr) ? 32'hDEAD_BEEF : mem_word(paddr);
                        pend       = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    typedef struct {
        logic        stall;
        int          lat;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pco;
        logic [31:0] npc;
        logic [31:0] ins;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // stall lat | req addr valid pc_out next_pc instr
        vecs[0]  = '{1'b0, 1, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0};
        vecs[1]  = '{1'b0, 1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  32'h0};
        vecs[2]  = '{1'b0, 1, 1'b1, 32'h4,  1'b1, 32'h0,  32'h4,  32'hA5A5_0000};
        vecs[3]  = '{1'b0, 1, 1'b0, 32'h4,  1'b0, 32'h0,  32'h4,  32'hA5A5_0000};
        vecs[4]  = '{1'b0, 1, 1'b1, 32'h8,  1'b1, 32'h4,  32'h8,  32'hA5A5_0004};
        vecs[5]  = '{1'b0, 1, 1'b0, 32'h8,  1'b0, 32'h4,  32'h8,  32'hA5A5_0004};
        vecs[6]  = '{1'b0, 1, 1'b1, 32'hC,  1'b1, 32'h8,  32'hC,  32'hA5A5_0008};
        vecs[7]  = '{1'b1, 1, 1'b0, 32'hC,  1'b0, 32'h8,  32'hC,  32'hA5A5_0008};
        vecs[8]  = '{1'b1, 1, 1'b0, 32'h10, 1'b1, 32'hC,  32'h10, 32'hA5A5_000C};
        vecs[9]  = '{1'b1, 1, 1'b0, 32'h10, 1'b1, 32'hC,  32'h10, 32'hA5A5_000C};
        vecs[10] = '{1'b1, 1, 1'b0, 32'h10, 1'b1, 32'hC,  32'h10, 32'hA5A5_000C};
        vecs[11] = '{1'b1, 1, 1'b0, 32'h10, 1'b1, 32'hC,  32'h10, 32'hA5A5_000C};
        vecs[12] = '{1'b1, 1, 1'b0, 32'h10, 1'b1, 32'hC,  32'h10, 32'hA5A5_000C};
        vecs[13] = '{1'b0, 2, 1'b1, 32'h10, 1'b1, 32'hC,  32'h10, 32'hA5A5_000C};

        resetn        = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        mem_ready     = 1'b1;
        lat           = 1;
        err_addr      = 32'hFFFF_FFFF;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset valid_out",   {31'd0, valid_out}, 32'd0);
        check("reset exception",   {31'd0, exception}, 32'd0);
        check("reset ecause",      {28'd0, ecause},    32'd0);
        check("reset instr",       instr,              32'd0);
        check("reset pc_out",      pc_out,             32'd0);
        check("reset next_pc_out", next_pc_out,        32'd0);
        check("reset mem_addr",    mem_addr,           32'h0);
        @(posedge clk);
        #3;
        resetn = 1'b1;

        // Streaming at 1-cycle latency, then a 5-cycle stall and release
        for (int r = 0; r < 14; r++) begin
            stall = vecs[r].stall;
            lat   = vecs[r].lat;
            @(negedge clk);
            check($sformatf("row%0d mem_req", r),     {31'd0, mem_req},   {31'd0, vecs[r].req});
            check($sformatf("row%0d mem_addr", r),    mem_addr,           vecs[r].addr);
            check($sformatf("row%0d valid_out", r),   {31'd0, valid_out}, {31'd0, vecs[r].valid});
            check($sformatf("row%0d pc_out", r),      pc_out,             vecs[r].pco);
            check($sformatf("row%0d next_pc_out", r), next_pc_out,        vecs[r].npc);
            check($sformatf("row%0d instr", r),       instr,              vecs[r].ins);
            step();
        end

        // Redirect to 0x100 while waiting on the response for 0x10
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);
        check("br100 wait mem_req", {31'd0, mem_req}, 32'd0);
        check("br100 wait mem_addr", mem_addr, 32'h10);
        step();
        branch_taken = 1'b0;
        @(negedge clk);
        check("br100 flush mem_req", {31'd0, mem_req}, 32'd0);
        check("br100 flush valid_out", {31'd0, valid_out}, 32'd0);
        check("br100 flush mem_addr", mem_addr, 32'h100);
        step();
        @(negedge clk);
        check("br100 req mem_req", {31'd0, mem_req}, 32'd1);
        check("br100 req mem_addr", mem_addr, 32'h100);
        step();
        wait_valid("br100", 10);
        check("br100 pc_out", pc_out, 32'h100);
        check("br100 next_pc_out", next_pc_out, 32'h104);
        check("br100 instr", instr, mem_word(32'h100));
        lat = 1;

        // Redirect to misaligned 0x102 with a same-cycle response
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        @(negedge clk);
        check("br102 wait mem_req", {31'd0, mem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        @(negedge clk);
        check("br102 req mem_req", {31'd0, mem_req}, 32'd0);
        check("br102 dropped valid_out", {31'd0, valid_out}, 32'd0);
        check("br102 mem_addr", mem_addr, 32'h102);
        step();
        @(negedge clk);
        check("misalign valid_out", {31'd0, valid_out}, 32'd1);
        check("misalign exception", {31'd0, exception}, 32'd1);
        check("misalign ecause", {28'd0, ecause}, 32'd0);
        check("misalign pc_out", pc_out, 32'h102);
        check("misalign instr", instr, 32'd0);
        check("misalign mem_req", {31'd0, mem_req}, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("halt%0d mem_req", i), {31'd0, mem_req}, 32'd0);
            step();
        end

        // Leave HALT by redirecting to 0x200; hold the result with stall
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        stall         = 1'b1;
        @(negedge clk);
        check("br200 halt mem_req", {31'd0, mem_req}, 32'd0);
        step();
        branch_taken = 1'b0;
        @(negedge clk);
        check("br200 mem_req", {31'd0, mem_req}, 32'd1);
        check("br200 mem_addr", mem_addr, 32'h200);
        step();
        wait_valid("br200", 10);
        check("br200 pc_out", pc_out, 32'h200);
        check("br200 next_pc_out", next_pc_out, 32'h204);
        check("br200 exception", {31'd0, exception}, 32'd0);
        check("br200 instr", instr, mem_word(32'h200));

        // Asynchronous reset mid-cycle, then restart from the reset vector
        #2;
        resetn = 1'b0;
        #1;
        check("async reset valid_out", {31'd0, valid_out}, 32'd0);
        check("async reset pc_out", pc_out, 32'd0);
        check("async reset mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        stall  = 1'b0;
        @(negedge clk);
        check("post-reset mem_req", {31'd0, mem_req}, 32'd1);
        check("post-reset mem_addr", mem_addr, 32'h0);
        step();
        wait_valid("post-reset", 10);
        check("post-reset pc_out", pc_out, 32'h0);
        check("post-reset instr", instr, mem_word(32'h0));

        // Access fault at 0x40
        err_addr = 32'h40;
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        @(negedge clk);
        check("fault mem_req", {31'd0, mem_req}, 32'd1);
        check("fault mem_addr", mem_addr, 32'h40);
        step();
        wait_valid("fault", 10);
        check("fault exception", {31'd0, exception}, 32'd1);
        check("fault ecause", {28'd0, ecause}, 32'd1);
        check("fault pc_out", pc_out, 32'h40);
        check("fault instr", instr, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("fault halt%0d mem_req", i), {31'd0, mem_req}, 32'd0);
            check($sformatf("fault halt%0d mem_addr", i), mem_addr, 32'h40);
            step();
        end

        // PC wrap from the top of the address space
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        @(negedge clk);
        check("wrap mem_req", {31'd0, mem_req}, 32'd1);
        check("wrap mem_addr", mem_addr, 32'hFFFF_FFFC);
        step();
        wait_valid("wrap", 10);
        check("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap next_pc_out", next_pc_out, 32'h0);
        check("wrap exception", {31'd0, exception}, 32'd0);
        check("wrap instr", instr, mem_word(32'hFFFF_FFFC));
        check("wrap next mem_addr", mem_addr, 32'h0);
        check("wrap next mem_req", {31'd0, mem_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 mem_req  out  1  instruction-memory read request valid.
REQ-006 mem_addr  out  32  request address, equal to internal fetch PC.
REQ-007 mem_ready  in  1  request accepted when mem_req && mem_ready at a clock edge.
REQ-008 mem_rvalid  in  1  response valid, at least 1 cycle after acceptance, in order.
REQ-009 mem_rdata  in  32  response instruction word.
REQ-010 mem_error  in  1  access fault, qualified by mem_rvalid.
REQ-011 stall  in  1  decode cannot accept; output is consumed at an edge with valid_out && !stall.
REQ-012 branch_taken  in  1  single-cycle redirect request from execute.
REQ-013 branch_target  in  32  redirect address, qualified by branch_taken.
REQ-014 instr, pc_out, next_pc_out  out  32 each  fetched word, its address, address+4.
REQ-015 valid_out  out  1  output register holds a valid entry.
REQ-016 exception  out  1, ecause  out  4  fetch fault flag and cause (0 misaligned, 1 access fault).

Function
REQ-017 Internal state: fetch PC (32 bits), one-entry output register, and FSM with states REQ, WAIT, FLUSH, HALT.
REQ-018 At most one memory request is outstanding.
REQ-019 buf_free is valid_out==0, or valid_out && !stall (consumed this cycle).
REQ-020 mem_req = (state==REQ) && buf_free && (pc[1:0]==0); it is combinational on stall.
REQ-021 REQ: when mem_req && mem_ready, go to WAIT.
REQ-022 REQ: when pc[1:0]!=0 and buf_free, load the output register with exception=1, ecause=0, instr=0, pc_out=pc, and go to HALT.
REQ-023 WAIT: when mem_rvalid && !mem_error, load instr=mem_rdata, pc_out=pc, next_pc_out=pc+4, exception=0, valid_out=1; set pc to pc+4; go to REQ.
REQ-024 WAIT: when mem_rvalid && mem_error, load exception=1, ecause=1, instr=0, pc_out=pc, valid_out=1; go to HALT.
REQ-025 The output register holds its contents unchanged while valid_out && stall; valid_out clears on consumption unless it is reloaded in the same cycle.
REQ-026 Peak throughput is one instruction per 2 cycles; there is no combinational path from mem_rdata to any output.
REQ-027 branch_taken has priority over all other events in the same cycle.
REQ-028 On branch_taken: pc <= branch_target; valid_out <= 0 regardless of stall; any same-cycle response is discarded.
REQ-029 Next state after branch_taken: FLUSH if in WAIT without same-cycle mem_rvalid, or if in REQ with an accepted request that cycle, or if already in FLUSH without mem_rvalid; otherwise REQ.
REQ-030 FLUSH: mem_req=0; on mem_rvalid, drop the response (including mem_error) and go to REQ.
REQ-031 HALT: mem_req=0 and pc is not advanced; leave HALT only through branch_taken.
REQ-032 All arithmetic on pc is modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0 without error.
REQ-033 mem_addr equals pc in every state.

Reset
REQ-034 While resetn=0: state=REQ, pc=RESET_VECTOR, valid_out=0, exception=0, ecause=0, instr=0, pc_out=0, next_pc_out=0.
REQ-035 Reset asserted mid-request abandons any outstanding response; the memory side is reset by the same signal.
REQ-036 mem_req may assert in the first cycle after resetn rises.

Verification
REQ-037 Reset release, mem_ready=1, rdata at 1-cycle latency, stall=0 -> addresses 0,4,8 requested; valid_out every second cycle with pc_out 0,4,8 and next_pc_out 4,8,12.
REQ-038 stall=1 held for 5 cycles with valid_out=1 -> outputs stable, mem_req=0 after the next response; release -> next fetch issued in the same cycle.
REQ-039 branch_taken (target 32'h100) while in WAIT -> the following response is dropped, the next mem_addr=32'h100, and no valid_out occurs with stale pc_out.
REQ-040 branch_taken (target 32'h102) -> no mem_req; output exception=1, ecause=0, pc_out=32'h102; the block stays idle until branch_taken to 32'h200 resumes fetching.
REQ-041 Response with mem_error=1 at pc 32'h40 -> exception=1, ecause=1, pc_out=32'h40, then HALT with mem_req=0.
REQ-042 resetn pulsed low while in WAIT -> valid_out=0 immediately (asynchronously), and the first request after release is to RESET_VECTOR.
